// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch front end:
//   - fetch_state_t : fetch sequencer states
//   - width, reset-PC and EBREAK encoding defaults
//   - target_misaligned() : word-alignment check on a fetch target
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int          DATA_WIDTH          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] EBREAK_WORD_DEFAULT = 32'h0010_0073;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    // Instructions are 32-bit words, so any set bit in [1:0] is a bad target.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC selection for the instruction in EXEC.
// Ports:
//   pc, pc_plus4        current PC and its sequential successor
//   imm                 sign-extended immediate (branch / JAL offset)
//   alu_result          datapath ALU output (rs1+imm for JALR)
//   jump, jalr          JAL / JALR decode
//   branch, branch_inv  conditional branch decode, invert sense for BNE
//   eq                  datapath equality flag
//   target              selected next PC
//   misaligned          target is not word aligned
// -----------------------------------------------------------------------------
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter int Data_Width = DATA_WIDTH
) (
    input  logic [Data_Width-1:0] pc,
    input  logic [Data_Width-1:0] pc_plus4,
    input  logic [Data_Width-1:0] imm,
    input  logic [Data_Width-1:0] alu_result,
    input  logic                  jump,
    input  logic                  jalr,
    input  logic                  branch,
    input  logic                  branch_inv,
    input  logic                  eq,
    output logic [Data_Width-1:0] target,
    output logic                  misaligned
);

    // Priority: JALR, then JAL, then taken branch, else fall through.
    always_comb begin
        target = pc_plus4;
        if (jump) begin
            if (jalr) begin
                // JALR clears bit 0 of the computed address.
                target = {alu_result[Data_Width-1:1], 1'b0};
            end else begin
                target = pc + imm;
            end
        end else if (branch && (eq ^ branch_inv)) begin
            target = pc + imm;
        end else begin
            target = pc_plus4;
        end
    end

    assign misaligned = target_misaligned(target[1:0]);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Owns the program counter, fetches one instruction at a time over a
// req/ready/valid memory handshake and presents it to the execute datapath
// with a one-cycle enable. Resolves branches/JAL/JALR from datapath flags.
// Ports:
//   clk, rst            clock, async active-high reset
//   run                 fetch enable (level)
//   imem_req/addr       fetch request and address (addr = pc)
//   imem_ready          memory accepts request
//   imem_valid/rdata    returned instruction
//   instr, instr_valid  latched instruction and one-cycle execute enable
//   pc, newPC           current PC and PC+4 link value
//   branch, branch_inv, jump, jalr, ImmOp, alu_result, eq   resolve inputs
//   halted, fault       in HALT; sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                  Data_Width  = DATA_WIDTH,
    parameter logic [Data_Width-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [Data_Width-1:0] EBREAK_WORD = EBREAK_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  imem_req,
    output logic [Data_Width-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_valid,
    input  logic [Data_Width-1:0] imem_rdata,
    output logic [Data_Width-1:0] instr,
    output logic                  instr_valid,
    output logic [Data_Width-1:0] pc,
    output logic [Data_Width-1:0] newPC,
    input  logic                  branch,
    input  logic                  branch_inv,
    input  logic                  jump,
    input  logic                  jalr,
    input  logic [Data_Width-1:0] ImmOp,
    input  logic [Data_Width-1:0] alu_result,
    input  logic                  eq,
    output logic                  halted,
    output logic                  fault
);

    fetch_state_t            state_r;
    fetch_state_t            next_state;
    logic [Data_Width-1:0]   pc_r;
    logic [Data_Width-1:0]   instr_r;
    logic                    req_r;
    logic                    valid_r;
    logic                    halted_r;
    logic                    fault_r;
    logic [Data_Width-1:0]   pc_plus4;
    logic [Data_Width-1:0]   target;
    logic                    target_bad;

    assign pc_plus4 = pc_r + {{(Data_Width-3){1'b0}}, 3'd4};

    next_pc_sel #(.Data_Width(Data_Width)) u_next_pc_sel (
        .pc         (pc_r),
        .pc_plus4   (pc_plus4),
        .imm        (ImmOp),
        .alu_result (alu_result),
        .jump       (jump),
        .jalr       (jalr),
        .branch     (branch),
        .branch_inv (branch_inv),
        .eq         (eq),
        .target     (target),
        .misaligned (target_bad)
    );

    // Fetch sequencer next-state logic.
    always_comb begin
        next_state = state_r;
        case (state_r)
            IDLE: begin
                if (run) next_state = FETCH;
                else     next_state = IDLE;
            end
            FETCH: begin
                // Acceptance wins over a same-cycle drop of run.
                if (imem_ready) next_state = WAIT;
                else if (!run)  next_state = IDLE;
                else            next_state = FETCH;
            end
            WAIT: begin
                if (imem_valid) begin
                    if (imem_rdata == EBREAK_WORD) next_state = HALT;
                    else                           next_state = EXEC;
                end else begin
                    next_state = WAIT;
                end
            end
            EXEC: begin
                if (target_bad) next_state = HALT;
                else if (run)   next_state = FETCH;
                else            next_state = IDLE;
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // State register and registered state-decoded outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            req_r    <= 1'b0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_state;
            req_r    <= (next_state == FETCH);
            valid_r  <= (next_state == EXEC);
            halted_r <= (next_state == HALT);
        end
    end

    // Instruction latch; only a response during WAIT is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= {Data_Width{1'b0}};
        end else if ((state_r == WAIT) && imem_valid) begin
            instr_r <= imem_rdata;
        end
    end

    // PC update at the end of EXEC; a bad target freezes pc and sets fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            fault_r <= 1'b0;
        end else if (state_r == EXEC) begin
            if (target_bad) fault_r <= 1'b1;
            else            pc_r    <= target;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign newPC       = pc_plus4;
    assign halted      = halted_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Scoreboard bench: stimulus pushes expected fetch addresses and execute
// records; a monitor pops and compares on each memory handshake and on each
// instr_valid pulse. A responder models instruction memory with programmable
// ready/valid delays.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        int          lat;
    } exec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] newPC;
    logic        branch, branch_inv, jump, jalr, eq;
    logic [31:0] ImmOp, alu_result;
    logic        halted, fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_fetch[$];
    exec_t       exp_exec[$];

    // memory model controls
    logic [31:0] mem_word  = 32'h0000_0013;
    int          ready_dly = 0;
    int          valid_dly = 0;

    // monitor statistics
    int          cycle      = 0;
    int          req_start  = 0;
    int          req_cycles = 0;
    int          hs_count   = 0;
    int          exec_count = 0;
    logic        prev_req   = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .newPC      (newPC),
        .branch     (branch),
        .branch_inv (branch_inv),
        .jump       (jump),
        .jalr       (jalr),
        .ImmOp      (ImmOp),
        .alu_result (alu_result),
        .eq         (eq),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory responder.
    initial begin : responder
        logic hs;
        logic busy;
        int   rcnt;
        int   vcnt;
        busy = 1'b0; rcnt = 0; vcnt = 0;
        imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            hs = imem_req && imem_ready;
            @(posedge clk);
            #2;
            imem_ready = 1'b0;
            imem_valid = 1'b0;
            if (hs) begin
                busy = 1'b1;
                vcnt = 0;
            end
            if (busy) begin
                if (vcnt == valid_dly) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word;
                    busy       = 1'b0;
                end else begin
                    vcnt++;
                end
            end
            if (imem_req && !hs) begin
                if (rcnt == ready_dly) begin
                    imem_ready = 1'b1;
                    rcnt       = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exec_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            cycle++;
            if (imem_req && !prev_req) req_start = cycle;
            if (imem_req && prev_req) chk("addr_stable", imem_addr, prev_addr);
            if (imem_req) req_cycles++;
            if (imem_req && imem_ready) begin
                hs_count++;
                if (exp_fetch.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
                end else begin
                    a = exp_fetch.pop_front();
                    chk("fetch_addr", imem_addr, a);
                end
            end
            if (instr_valid) begin
                exec_count++;
                if (exp_exec.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_exec: got instr %h expected none", instr);
                end else begin
                    e = exp_exec.pop_front();
                    chk("exec_pc", pc, e.pc);
                    chk("exec_instr", instr, e.instr);
                    chk("exec_newPC", newPC, e.npc);
                    if (e.lat >= 0) chk("exec_latency", 32'(cycle - req_start), 32'(e.lat));
                end
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
        end
    end

    // Queue one instruction fetch/execute and wait for its execute pulse.
    task automatic issue(input logic [31:0] addr, input logic [31:0] word,
                         input logic br, input logic inv, input logic jmp, input logic jr,
                         input logic [31:0] imm, input logic [31:0] alu, input logic eqv,
                         input int rd, input int vd, input int lat);
        exec_t e;
        int    n;
        mem_word = word; ready_dly = rd; valid_dly = vd;
        branch = br; branch_inv = inv; jump = jmp; jalr = jr;
        ImmOp = imm; alu_result = alu; eq = eqv;
        exp_fetch.push_back(addr);
        e.pc = addr; e.instr = word; e.npc = addr + 32'd4; e.lat = lat;
        exp_exec.push_back(e);
        n = exec_count;
        for (int i = 0; i < 80 && exec_count == n; i++) begin
            @(posedge clk);
            #1;
        end
        if (exec_count == n) begin
            checks++; errors++;
            $display("FAIL exec_timeout: got no instr_valid expected pulse at pc %h", addr);
        end
    endtask

    task automatic nop(input logic [31:0] addr);
        issue(addr, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 2);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int rq;
        rst = 1'b1; run = 1'b0;
        branch = 1'b0; branch_inv = 1'b0; jump = 1'b0; jalr = 1'b0;
        ImmOp = 32'h0; alu_result = 32'h0; eq = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        @(posedge clk); #1;

        // basic zero-wait fetch
        run = 1'b1;
        issue(32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 2);
        nop(32'h4);
        nop(32'h8);
        nop(32'hC);
        // BEQ taken backwards
        issue(32'h10, 32'hFE00_0CE3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b1, 0, 0, 2);
        nop(32'h8);
        nop(32'hC);
        // BEQ not taken
        issue(32'h10, 32'hFE00_0CE3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 0, 0, 2);
        // JAL back to 0x10
        issue(32'h14, 32'hFFDF_F06F, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 0, 0, 2);
        // BNE taken on eq=0
        issue(32'h10, 32'hFE00_1CE3, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 0, 0, 2);
        // JALR, bit 0 cleared -> top of address space
        issue(32'h8, 32'h0000_80E7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFD, 1'b0, 0, 0, 2);
        // newPC wraps to 0
        nop(32'hFFFF_FFFC);
        // slow memory: ready held off 3 cycles, valid 2 cycles late
        issue(32'h0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3, 2, 7);
        // JAL to 0x20
        issue(32'h4, 32'h01C0_006F, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_001C, 32'h0, 1'b0, 0, 0, 2);
        // JALR to misaligned 0x102
        issue(32'h20, 32'h0000_80E7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0103, 1'b0, 0, 0, 2);
        rq = req_cycles;
        wait_cycles(10);
        chk("fault_set", {31'h0, fault}, 32'h1);
        chk("fault_halted", {31'h0, halted}, 32'h1);
        chk("fault_pc_held", pc, 32'h20);
        chk("fault_no_req", 32'(req_cycles - rq), 32'h0);

        // reset out of HALT
        rst = 1'b1; run = 1'b0;
        wait_cycles(2);
        chk("rst2_fault", {31'h0, fault}, 32'h0);
        chk("rst2_pc", pc, 32'h0);
        rst = 1'b0;
        run = 1'b1;
        nop(32'h0);

        // reset while waiting for read data; the late response must be dropped
        mem_word = 32'h1234_5678; valid_dly = 1; ready_dly = 0;
        exp_fetch.push_back(32'h4);
        n = hs_count;
        for (int i = 0; i < 40 && hs_count == n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rstwait_handshake", 32'(hs_count - n), 32'h1);
        n = exec_count;
        rst = 1'b1; run = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(4);
        chk("rstwait_pc", pc, 32'h0);
        chk("rstwait_instr", instr, 32'h0);
        chk("rstwait_no_exec", 32'(exec_count - n), 32'h0);
        chk("rstwait_idle_req", {31'h0, imem_req}, 32'h0);
        run = 1'b1;
        nop(32'h0);

        // EBREAK halts without an execute pulse
        n = exec_count;
        mem_word = EBREAK; ready_dly = 0; valid_dly = 0;
        exp_fetch.push_back(32'h4);
        for (int i = 0; i < 40 && !halted; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ebreak_halted", {31'h0, halted}, 32'h1);
        rq = req_cycles;
        for (int i = 0; i < 8; i++) begin
            run = ~run;
            wait_cycles(2);
        end
        chk("ebreak_still_halted", {31'h0, halted}, 32'h1);
        chk("ebreak_no_req", 32'(req_cycles - rq), 32'h0);
        chk("ebreak_no_exec", 32'(exec_count - n), 32'h0);
        chk("ebreak_instr", instr, EBREAK);
        chk("ebreak_pc", pc, 32'h4);
        chk("ebreak_no_fault", {31'h0, fault}, 32'h0);

        chk("fetch_queue_empty", 32'(exp_fetch.size()), 32'h0);
        chk("exec_queue_empty", 32'(exp_exec.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Upstream neighbour of the single-cycle execute datapath (regfile, ALU, data RAM, result muxes). Owns the program counter and fetches each instruction from instruction memory over a req/ready/valid handshake. Presents one instruction per execute slot with a one-cycle enable, and supplies PC+4 to the result PC mux. Consumes the datapath's eq flag and ALU result to resolve branches, JAL and JALR.

Parameters:
Data_Width, 32, instruction/PC/data width
RESET_PC, 32'h0000_0000, PC loaded on reset
EBREAK_WORD, 32'h0010_0073, instruction encoding that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; fetch proceeds only while high
imem_req  out  1  fetch request
imem_addr  out  Data_Width  fetch address; equals pc while imem_req high
imem_ready  in  1  memory accepts request when imem_req&imem_ready
imem_valid  in  1  read data valid
imem_rdata  in  Data_Width  fetched instruction
instr  out  Data_Width  latched instruction to decoder/datapath
instr_valid  out  1  one-cycle execute enable; datapath gates regFileWen/MemWrite with it
pc  out  Data_Width  address of current instr
newPC  out  Data_Width  pc+4, to result PC mux (link value)
branch  in  1  decoded conditional branch
branch_inv  in  1  take on !eq (BNE) instead of eq (BEQ)
jump  in  1  decoded JAL/JALR
jalr  in  1  jump target from ALU (with jump)
ImmOp  in  Data_Width  sign-extended immediate
alu_result  in  Data_Width  datapath ALUout (rs1+imm for JALR)
eq  in  1  datapath zero/equal flag
halted  out  1  high in HALT
fault  out  1  sticky; misaligned target taken

Behaviour:
- Reset (async assert, sync-released by flops): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, fault=0. Reset mid-transaction abandons it; later stray imem_valid ignored.
- newPC = pc+4 combinationally, modulo 2^Data_Width (wraps 0xFFFF_FFFC -> 0).
- States:
  IDLE: outputs quiet; run=1 -> FETCH next cycle.
  FETCH: imem_req=1, imem_addr=pc held stable; imem_req&imem_ready -> WAIT; run=0 while not yet accepted -> IDLE (request withdrawn).
  WAIT: imem_req=0; on imem_valid latch instr<=imem_rdata -> EXEC. If imem_rdata==EBREAK_WORD latch it but go HALT (no EXEC pulse).
  EXEC: instr_valid=1 exactly this cycle; decode inputs/eq/alu_result sampled at its end; pc updates on that edge; next state FETCH if run else IDLE.
  HALT: halted=1, no requests; leaves only on rst.
- Next-PC priority in EXEC: jump&jalr -> {alu_result[31:1],1'b0}; jump&!jalr -> pc+ImmOp; branch&(eq^branch_inv) -> pc+ImmOp; else pc+4. Add is wrap-around 32-bit.
- Selected target with bits[1:0]!=0: pc not updated, fault<=1, state->HALT.
- imem_valid outside WAIT ignored; imem_ready outside FETCH ignored.
- Minimum latency: FETCH->WAIT->EXEC = 3 cycles/instruction with zero-wait memory (ready and valid same cycle as offered).
- instr and pc hold their values outside EXEC (stable for debug).

Decomposition:
- Shared package riscv_pkg: fetch_state_t enum {IDLE,FETCH,WAIT,EXEC,HALT}, EBREAK_WORD, RESET_PC default, width constants.
- Sub-module next_pc_sel (combinational target select + misalignment flag); FSM, PC and instr registers stay in pc_fetch_unit.

Test Plan:
- rst, run=1, zero-wait memory returning 0x00500093 -> imem_addr=0 in FETCH, instr_valid pulses third cycle, pc 0 -> 4, newPC=4 during EXEC.
- BEQ at pc=0x10, ImmOp=0xFFFF_FFF8, eq=1 -> next imem_addr=0x08; same with eq=0 -> 0x14; branch_inv=1, eq=0 -> 0x08.
- JALR at pc=0x20, alu_result=0x0000_0103 -> pc=0x102 misaligned -> fault=1, halted=1, no further imem_req.
- imem_ready low 3 cycles then valid delayed 2 cycles -> imem_addr stable throughout, exactly one instr_valid pulse.
- fetch returns 0x0010_0073 -> halted=1, instr_valid never asserted, run toggling has no effect until rst.
- rst asserted during WAIT, imem_valid arrives next cycle -> ignored; pc=RESET_PC, instr=0, restart fetch at RESET_PC.
